// File: rtl/object_stats_pkg.sv
// Purpose: shared widths, FSM state encoding and record layout for the object statistics block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package object_stats_pkg;

    // Label bus follows the labeller word size.
    localparam int WORD_SIZE       = 8;
    localparam int LABEL_WIDTH     = WORD_SIZE;
    localparam int NUM_LABELS_DEF  = 64;
    localparam int COORD_WIDTH_DEF = 11;
    localparam int COUNT_WIDTH_DEF = 20;

    // ACCUM gathers pixels, DUMP walks the table, DONE is the one-cycle completion pulse.
    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_DUMP  = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Record field order when packed into one word, MSB first:
    // {label, xmin, xmax, ymin, ymax, count}
    function automatic int rec_width(input int label_w, input int coord_w, input int count_w);
        return label_w + 4 * coord_w + count_w;
    endfunction

endpackage

// File: rtl/stats_entry_update.sv
// Purpose: merge one pixel (x,y) into a table entry: min/max bounding box and saturating count.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module stats_entry_update #(
    parameter int COORD_WIDTH = 11,
    parameter int COUNT_WIDTH = 20
) (
    input  logic [COUNT_WIDTH-1:0] cnt_i,
    input  logic [COORD_WIDTH-1:0] xmin_i,
    input  logic [COORD_WIDTH-1:0] xmax_i,
    input  logic [COORD_WIDTH-1:0] ymin_i,
    input  logic [COORD_WIDTH-1:0] ymax_i,
    input  logic [COORD_WIDTH-1:0] x_i,
    input  logic [COORD_WIDTH-1:0] y_i,
    output logic [COUNT_WIDTH-1:0] cnt_o,
    output logic [COORD_WIDTH-1:0] xmin_o,
    output logic [COORD_WIDTH-1:0] xmax_o,
    output logic [COORD_WIDTH-1:0] ymin_o,
    output logic [COORD_WIDTH-1:0] ymax_o
);

    // An empty entry is seeded from the pixel; otherwise widen the box and bump the count.
    always_comb begin
        cnt_o  = cnt_i;
        xmin_o = xmin_i;
        xmax_o = xmax_i;
        ymin_o = ymin_i;
        ymax_o = ymax_i;
        if (cnt_i == '0) begin
            cnt_o  = COUNT_WIDTH'(1);
            xmin_o = x_i;
            xmax_o = x_i;
            ymin_o = y_i;
            ymax_o = y_i;
        end else begin
            if (x_i < xmin_i) xmin_o = x_i;
            if (x_i > xmax_i) xmax_o = x_i;
            if (y_i < ymin_i) ymin_o = y_i;
            if (y_i > ymax_i) ymax_o = y_i;
            // Hold at all-ones rather than wrapping back to "empty".
            if (!(&cnt_i)) cnt_o = cnt_i + COUNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/object_stats.sv
// Purpose: per-label bounding box + pixel count over a frame, dumped as one record per non-empty label.
// Latency: pixel visible in table next cycle; first record >= 2 cycles after frame_end, 1 cycle per empty entry.
// Backpressure: out_* held stable while out_valid && !out_ready; pixels arriving during the dump are dropped and flagged.
module object_stats
    import object_stats_pkg::*;
#(
    parameter int NUM_LABELS  = NUM_LABELS_DEF,
    parameter int COORD_WIDTH = COORD_WIDTH_DEF,
    parameter int COUNT_WIDTH = COUNT_WIDTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   en,
    input  logic                   frame_end,
    input  logic [31:0]            x,
    input  logic [31:0]            y,
    input  logic [LABEL_WIDTH-1:0] label,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LABEL_WIDTH-1:0] out_label,
    output logic [COORD_WIDTH-1:0] out_xmin,
    output logic [COORD_WIDTH-1:0] out_xmax,
    output logic [COORD_WIDTH-1:0] out_ymin,
    output logic [COORD_WIDTH-1:0] out_ymax,
    output logic [COUNT_WIDTH-1:0] out_count,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   overflow
);

    localparam int IDX_W = $clog2(NUM_LABELS);
    localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(NUM_LABELS - 1);
    localparam logic [LABEL_WIDTH:0]   NL_EXT   = (LABEL_WIDTH + 1)'(NUM_LABELS);

    // Label table; entry 0 (background) is never written so its count stays zero.
    logic [COUNT_WIDTH-1:0] cnt_q  [NUM_LABELS];
    logic [COORD_WIDTH-1:0] xmin_q [NUM_LABELS];
    logic [COORD_WIDTH-1:0] xmax_q [NUM_LABELS];
    logic [COORD_WIDTH-1:0] ymin_q [NUM_LABELS];
    logic [COORD_WIDTH-1:0] ymax_q [NUM_LABELS];

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   out_valid_q;
    logic [LABEL_WIDTH-1:0] out_label_q;
    logic [COORD_WIDTH-1:0] out_xmin_q, out_xmax_q, out_ymin_q, out_ymax_q;
    logic [COUNT_WIDTH-1:0] out_count_q;
    logic                   busy_q;
    logic                   frame_done_q;
    logic                   overflow_q;

    logic                   lbl_in_range;
    logic [IDX_W-1:0]       lbl_idx;
    logic [IDX_W-1:0]       rd_idx;
    logic [COORD_WIDTH-1:0] px, py;
    logic [COUNT_WIDTH-1:0] cur_cnt;
    logic [COORD_WIDTH-1:0] cur_xmin, cur_xmax, cur_ymin, cur_ymax;
    logic [COUNT_WIDTH-1:0] ent_cnt_d;
    logic [COORD_WIDTH-1:0] ent_xmin_d, ent_xmax_d, ent_ymin_d, ent_ymax_d;
    logic                   pix_acc;
    logic                   dump_load;
    logic                   dump_adv;
    logic                   rec_take;
    logic                   unused_coord_hi;

    // Coordinates beyond COORD_WIDTH are deliberately discarded.
    assign px = x[COORD_WIDTH-1:0];
    assign py = y[COORD_WIDTH-1:0];
    assign unused_coord_hi = ^{x[31:COORD_WIDTH], y[31:COORD_WIDTH]};

    assign lbl_in_range = ({1'b0, label} < NL_EXT);
    assign lbl_idx      = label[IDX_W-1:0];

    // One read port: the pixel's label while accumulating, the walk index while dumping.
    assign rd_idx   = (state_q == ST_ACCUM) ? lbl_idx : idx_q;
    assign cur_cnt  = cnt_q[rd_idx];
    assign cur_xmin = xmin_q[rd_idx];
    assign cur_xmax = xmax_q[rd_idx];
    assign cur_ymin = ymin_q[rd_idx];
    assign cur_ymax = ymax_q[rd_idx];

    assign pix_acc   = (state_q == ST_ACCUM) && en && lbl_in_range && (label != '0);
    assign dump_load = (state_q == ST_DUMP) && !out_valid_q && (cur_cnt != '0);
    assign dump_adv  = (state_q == ST_DUMP) && (out_valid_q ? out_ready : (cur_cnt == '0));
    assign rec_take  = dump_adv && out_valid_q;

    stats_entry_update #(
        .COORD_WIDTH (COORD_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_merge (
        .cnt_i  (cur_cnt),
        .xmin_i (cur_xmin),
        .xmax_i (cur_xmax),
        .ymin_i (cur_ymin),
        .ymax_i (cur_ymax),
        .x_i    (px),
        .y_i    (py),
        .cnt_o  (ent_cnt_d),
        .xmin_o (ent_xmin_d),
        .xmax_o (ent_xmax_d),
        .ymin_o (ent_ymin_d),
        .ymax_o (ent_ymax_d)
    );

    // Counts define emptiness: written on accepted pixels, zeroed when the record is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_LABELS; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (pix_acc) begin
            cnt_q[rd_idx] <= ent_cnt_d;
        end else if (rec_take) begin
            cnt_q[rd_idx] <= '0;
        end
    end

    // Box fields are meaningless while the count is zero, so they need no reset or clear.
    always_ff @(posedge clk) begin
        if (pix_acc) begin
            xmin_q[rd_idx] <= ent_xmin_d;
            xmax_q[rd_idx] <= ent_xmax_d;
            ymin_q[rd_idx] <= ent_ymin_d;
            ymax_q[rd_idx] <= ent_ymax_d;
        end
    end

    // Control FSM with registered record bus and status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_ACCUM;
            idx_q        <= '0;
            out_valid_q  <= 1'b0;
            out_label_q  <= '0;
            out_xmin_q   <= '0;
            out_xmax_q   <= '0;
            out_ymin_q   <= '0;
            out_ymax_q   <= '0;
            out_count_q  <= '0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state_q)
                ST_ACCUM: begin
                    if (en && !lbl_in_range) overflow_q <= 1'b1;
                    // A pixel on the frame_end cycle is written this edge, before the walk reads it.
                    if (frame_end) begin
                        state_q <= ST_DUMP;
                        idx_q   <= IDX_W'(1);
                        busy_q  <= 1'b1;
                    end
                end
                ST_DUMP: begin
                    if (en) overflow_q <= 1'b1;
                    if (dump_load) begin
                        out_valid_q <= 1'b1;
                        out_label_q <= LABEL_WIDTH'(idx_q);
                        out_xmin_q  <= cur_xmin;
                        out_xmax_q  <= cur_xmax;
                        out_ymin_q  <= cur_ymin;
                        out_ymax_q  <= cur_ymax;
                        out_count_q <= cur_cnt;
                    end
                    if (rec_take) out_valid_q <= 1'b0;
                    if (dump_adv) begin
                        if (idx_q == LAST_IDX) begin
                            state_q      <= ST_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_DONE: begin
                    // Overflow was visible alongside frame_done; a pixel dropped now belongs to the next frame.
                    state_q    <= ST_ACCUM;
                    busy_q     <= 1'b0;
                    overflow_q <= en;
                end
                default: begin
                    state_q <= ST_ACCUM;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_label  = out_label_q;
    assign out_xmin   = out_xmin_q;
    assign out_xmax   = out_xmax_q;
    assign out_ymin   = out_ymin_q;
    assign out_ymax   = out_ymax_q;
    assign out_count  = out_count_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign overflow   = overflow_q;

endmodule

// File: doc/object_stats.md
Name: object_stats

Overview:
- Downstream of the connected-components labeller: consumes its per-pixel label stream plus the x/y from the location generator.
- Accumulates, per label, a bounding box (xmin/xmax/ymin/ymax) and a pixel count over one frame.
- At frame end, walks the label table and streams one record per non-empty label over a valid/ready interface, clearing entries as it goes.
- Its records are the detected-object list for overlay/host logic.

Parameters:
- NUM_LABELS, 64, table entries; label 0 is background and is never stored.
- LABEL_WIDTH, 8, label bus width (equals WORD_SIZE).
- COORD_WIDTH, 11, stored x/y width; inputs are truncated to this.
- COUNT_WIDTH, 20, pixel-count width; the counter saturates.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  pixel valid, same qualifier as the labeller
- frame_end  in  1  single-cycle pulse after the last pixel of a frame
- x  in  32  current pixel column
- y  in  32  current pixel row
- label  in  LABEL_WIDTH  labeller output for pixel (x,y)
- out_valid  out  1  record valid
- out_ready  in  1  consumer accepts record
- out_label  out  LABEL_WIDTH  record label
- out_xmin, out_xmax, out_ymin, out_ymax  out  COORD_WIDTH each  bounding box
- out_count  out  COUNT_WIDTH  pixel count
- busy  out  1  high while in DUMP
- frame_done  out  1  one-cycle pulse when the dump completes
- overflow  out  1  sticky per frame: a label ≥ NUM_LABELS was seen, or pixels were dropped during DUMP

Behaviour:
- Reset is asynchronous, active-low.
  - FSM goes to ACCUM and all entries clear (count=0).
  - All outputs reset to 0. Reset mid-dump abandons the dump; no frame_done.
- Entry fields: count, xmin, xmax, ymin, ymax.
  - The entry is empty when count == 0.
  - Fields are undefined while empty and are never emitted.
- ACCUM, each cycle with en=1 and 0 < label < NUM_LABELS:
  - If the entry is empty: xmin=xmax=x, ymin=ymax=y, count=1.
  - Otherwise: min/max update and count+1, saturating at all-ones.
  - The update is a single-cycle read-modify-write on a register array, so back-to-back pixels with the same label are correct with no bubble.
- label ≥ NUM_LABELS with en=1: pixel ignored, overflow set.
- label == 0: ignored.
- ACCUM + frame_end → DUMP, with idx=1. A pixel arriving on the same cycle as frame_end is accumulated first.
- DUMP:
  - If entry[idx] is empty: skip; idx+1 next cycle. Each empty entry costs 1 cycle.
  - If non-empty: register the record onto the out_* bus, out_valid=1 the cycle after idx is selected.
  - out_* stay stable while out_valid && !out_ready.
  - On a cycle with out_valid && out_ready: the entry clears and idx advances.
  - After idx == NUM_LABELS-1 is handled → DONE.
  - Records are emitted in ascending label order.
  - en=1 pixels during DUMP are dropped and set overflow.
  - frame_end during DUMP is ignored.
- DONE (1 cycle): frame_done=1, overflow clears, → ACCUM.
  - Overflow clears so it is sampled by the consumer alongside frame_done.
- busy=1 in DUMP and DONE.
- Latency:
  - A pixel is visible in the table the cycle after acceptance.
  - The first record appears ≥2 cycles after frame_end.

Decomposition:
- Shared package/global.vh: LABEL_WIDTH (=WORD_SIZE), COORD_WIDTH, the FSM state encodings ACCUM/DUMP/DONE, and the record field order for packing.
- One natural sub-module: stats_entry_update, a combinational min/max/saturating-count merge of an entry with (x,y).
  - Implemented once and shared via the index mux.

Test Plan:
1. Single blob: label 3 at (5,2),(6,2),(5,3); frame_end.
   - Expect exactly one record: label=3, xmin=5, xmax=6, ymin=2, ymax=3, count=3; then frame_done.
2. Multiple labels with back-pressure: labels 7 and 2 interleaved; out_ready low for 4 cycles on the first record.
   - Label 2 is emitted first and its fields are held stable for all 4 cycles.
   - Label 7 follows.
   - Next frame with no pixels: zero records, frame_done still pulses after NUM_LABELS-1 cycles.
3. Saturation: COUNT_WIDTH=4, 20 pixels of label 1 → count=15.
4. Overflow and background: label=200 plus label=0 pixels, then frame_end.
   - No records, overflow=1 until frame_done, then 0.
5. Pixels during dump: en=1, label=5 while busy=1 → dropped, overflow=1, entry 5 empty after DONE.
   - Also: a pixel on the same cycle as frame_end is included in its record.
6. Reset mid-dump: assert reset_n=0 while out_valid=1.
   - out_valid=0 immediately, no frame_done, next frame stats start empty.
